spi_boot_loader_ctrl: RTL and testbench
=======================================

// Module: spi_boot_loader_ctrl
// PURPOSE
//  Boot-load sequencer between the SPI program-load pins and instruction memory.
//  Deserialises 32-bit words (MSB first) arriving on spi_mosi_i while spi_ss_i is low.
//  Writes each word to consecutive memory addresses over a req/gnt port.
//  Releases the core (core_fetch_en_o) on en_i once all loaded words are committed.
// PARAMETERS
//  DATA_WIDTH  32            word width; only 32 supported
//  ADDR_WIDTH  32            memory byte-address width
//  BASE_ADDR   32'h0000_0000 byte address of the first loaded word
//  MAX_WORDS   4096          memory capacity in words; words beyond it are dropped
// PORTS
//  clk_i           in   1           system clock; all inputs synchronous to it
//  rst_ni          in   1           asynchronous active-low reset
//  sel_i           in   1           1 = load program over SPI; 0 = boot from memory as-is
//  spi_ss_i        in   1           active-low frame select
//  spi_mosi_i      in   1           serial data, sampled on clk_i rise while spi_ss_i=0
//  en_i            in   1           boot request (level)
//  mem_req_o       out  1           write request
//  mem_we_o        out  1           write enable; equals mem_req_o
//  mem_addr_o      out  ADDR_WIDTH  byte address, word aligned
//  mem_wdata_o     out  DATA_WIDTH  write data
//  mem_be_o        out  4           byte enables; 4'hF while mem_req_o=1, else 0
//  mem_gnt_i       in   1           grant; completes the request in the same cycle
//  core_fetch_en_o out  1           core fetch enable; sticky once set
//  load_busy_o     out  1           1 while in LOAD or while a write is pending
//  word_count_o    out  16          number of words granted since LOAD entry
//  err_overflow_o  out  1           sticky: word completed while previous write pending
//  err_full_o      out  1           sticky: word received after MAX_WORDS stored
//  err_frame_o     out  1           sticky: spi_ss_i rose mid-word
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; bit counter=0; shift register=0.
//  FSM states and transitions:
//   IDLE -> LOAD when sel_i=1. Entering LOAD clears word_count_o and all err_* flags.
//   IDLE -> BOOT when sel_i=0 and en_i=1.
//   LOAD -> BOOT when en_i=1 and no write is pending.
//   BOOT is terminal until reset; core_fetch_en_o=1 in BOOT.
//   sel_i is sampled in IDLE only.
//  Shifting (LOAD only):
//   - Each clock with spi_ss_i=0: shift = {shift[30:0], spi_mosi_i}; bitcnt++.
//   - On the 32nd bit the word is complete and bitcnt returns to 0.
//   - A clock with spi_ss_i=1 holds the shift register and bitcnt (idle gap, no error).
//   - spi_ss_i going 0->1 with bitcnt!=0: discard the partial word, set bitcnt=0,
//     set err_frame_o.
//  Write handshake:
//   - A completed word raises mem_req_o on the next cycle (1-cycle latency).
//   - mem_addr_o = BASE_ADDR + 4*word_count_o.
//   - mem_req_o, mem_addr_o and mem_wdata_o stay stable until mem_gnt_i=1 at a rising edge.
//   - On that grant: word_count_o++, and mem_req_o drops on the next cycle unless a
//     new word completed in the same cycle.
//   - Back-to-back case: grant and word completion in the same cycle -> the new
//     request issues next cycle with address +4.
//   - Word completes while a request is pending and not granted this cycle: drop the
//     new word, set err_overflow_o, keep the pending request unchanged.
//   - Word completes with word_count_o==MAX_WORDS: no request, set err_full_o.
//  Boot gating:
//   - en_i=1 during LOAD while a write is pending (or completing in this cycle):
//     stay in LOAD until the grant; enter BOOT on the cycle after the grant.
//   - A partially shifted word at BOOT entry is discarded silently.
//  Reset mid-operation: an asserted rst_ni drops mem_req_o and core_fetch_en_o immediately
//   (asynchronously); partial data is lost.
// TESTING
//  1. sel_i=1, shift 3 words 0x00000013, 0xDEADBEEF, 0x12345678 (mem_gnt_i tied 1), then
//     en_i=1 -> writes at 0x0,0x4,0x8 with matching data; word_count_o=3;
//     core_fetch_en_o=1 one cycle after en_i; no error flags.
//  2. mem_gnt_i held 0 for 40 cycles while 2 words are shifted back-to-back ->
//     only the first word is held on the bus; err_overflow_o=1; after the grant
//     word_count_o=1.
//  3. Raise spi_ss_i after 17 bits, then send a full 0xA5A5A5A5 ->
//     err_frame_o=1; a single write of 0xA5A5A5A5 to address 0x0.
//  4. MAX_WORDS=2, send 3 words -> 2 writes issued; err_full_o=1; word_count_o=2.
//  5. en_i asserted the cycle the last word completes, grant delayed 5 cycles ->
//     core_fetch_en_o rises on the cycle after the grant, never before.
//  6. sel_i=0, en_i=1 from reset release -> BOOT next cycle; no mem_req_o ever.
//     Separately, assert rst_ni low mid-request -> mem_req_o=0 asynchronously.

Source files
------------

// File: rtl/spi_boot_loader_ctrl.sv
// ============================================================================
//  Module   : spi_boot_loader_ctrl
//  Brief    : Boot-load sequencer. Deserialises 32-bit MSB-first words from the
//             SPI program-load pins, writes them to consecutive instruction
//             memory addresses over a req/gnt port, then releases the core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_boot_loader_ctrl #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            MAX_WORDS  = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sel_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  input  logic                  en_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  output logic                  core_fetch_en_o,
  output logic                  load_busy_o,
  output logic [15:0]           word_count_o,
  output logic                  err_overflow_o,
  output logic                  err_full_o,
  output logic                  err_frame_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BOOT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]           count_q, count_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_full_q, err_full_d;
  logic                  err_frame_q, err_frame_d;

  logic [DATA_WIDTH-1:0] word_w;
  logic                  word_done_w;
  logic                  gnt_w;
  logic [16:0]           used_w;

  // Serial word assembly and the write-port bookkeeping it feeds.
  assign word_w      = {shift_q[DATA_WIDTH-2:0], spi_mosi_i};
  assign word_done_w = (state_q == ST_LOAD) && !spi_ss_i && (bitcnt_q == 5'd31);
  assign gnt_w       = req_q && mem_gnt_i;
  // Words already committed plus the one on the bus; a granted word still
  // counts here because it becomes part of word_count_o at this edge.
  assign used_w      = {1'b0, count_q} + {16'b0, req_q};

  // Next-state logic: FSM, shifter, write request and sticky error flags.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    req_d       = req_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    err_ovf_d   = err_ovf_q;
    err_full_d  = err_full_q;
    err_frame_d = err_frame_q;

    case (state_q)
      ST_IDLE: begin
        shift_d  = '0;
        bitcnt_d = '0;
        if (sel_i) begin
          state_d     = ST_LOAD;
          count_d     = '0;
          err_ovf_d   = 1'b0;
          err_full_d  = 1'b0;
          err_frame_d = 1'b0;
        end else if (en_i) begin
          state_d = ST_BOOT;
        end
      end

      ST_LOAD: begin
        if (gnt_w) begin
          count_d = count_q + 16'd1;
          req_d   = 1'b0;
        end

        if (!spi_ss_i) begin
          shift_d = word_w;
          if (word_done_w) begin
            bitcnt_d = '0;
            if (req_q && !mem_gnt_i) begin
              // Bus still busy with the previous word: drop this one.
              err_ovf_d = 1'b1;
            end else if (used_w >= 17'(MAX_WORDS)) begin
              err_full_d = 1'b1;
            end else begin
              req_d   = 1'b1;
              wdata_d = word_w;
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else if (bitcnt_q != 5'd0) begin
          // Frame closed mid-word: the partial word is discarded.
          shift_d     = '0;
          bitcnt_d    = '0;
          err_frame_d = 1'b1;
        end

        // Boot waits until nothing is pending or about to become pending.
        if (en_i && !req_q && !word_done_w) begin
          state_d = ST_BOOT;
        end
      end

      ST_BOOT: begin
        shift_d  = '0;
        bitcnt_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      req_q       <= 1'b0;
      wdata_q     <= '0;
      count_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_full_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      req_q       <= req_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      err_ovf_q   <= err_ovf_d;
      err_full_q  <= err_full_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign mem_req_o       = req_q;
  assign mem_we_o        = req_q;
  assign mem_be_o        = {4{req_q}};
  assign mem_wdata_o     = wdata_q;
  assign mem_addr_o      = BASE_ADDR + (ADDR_WIDTH'(count_q) << 2);
  assign core_fetch_en_o = (state_q == ST_BOOT);
  assign load_busy_o     = (state_q == ST_LOAD) || req_q;
  assign word_count_o    = count_q;
  assign err_overflow_o  = err_ovf_q;
  assign err_full_o      = err_full_q;
  assign err_frame_o     = err_frame_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_boot_loader_ctrl.sv
// ============================================================================
//  Module   : tb_spi_boot_loader_ctrl
//  Brief    : Self-checking bench for spi_boot_loader_ctrl: a vector table for
//             plain word loading plus directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_boot_loader_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sel_i = 1'b0;
  logic        spi_ss_i = 1'b1;
  logic        spi_mosi_i = 1'b0;
  logic        en_i = 1'b0;
  logic        mem_gnt_i = 1'b0;

  logic        mem_req_o, mem_we_o, core_fetch_en_o, load_busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [15:0] word_count_o;
  logic        err_overflow_o, err_full_o, err_frame_o;

  logic        s_req, s_we, s_fetch, s_busy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [15:0] s_cnt;
  logic        s_ovf, s_full, s_frame;

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_q[$];
  logic [63:0] wr_s_q[$];

  always #5 clk_i = ~clk_i;

  spi_boot_loader_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sel_i(sel_i), .spi_ss_i(spi_ss_i),
    .spi_mosi_i(spi_mosi_i), .en_i(en_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .core_fetch_en_o(core_fetch_en_o), .load_busy_o(load_busy_o),
    .word_count_o(word_count_o), .err_overflow_o(err_overflow_o),
    .err_full_o(err_full_o), .err_frame_o(err_frame_o)
  );

  spi_boot_loader_ctrl #(.MAX_WORDS(2)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .sel_i(sel_i), .spi_ss_i(spi_ss_i),
    .spi_mosi_i(spi_mosi_i), .en_i(en_i), .mem_req_o(s_req), .mem_we_o(s_we),
    .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .mem_be_o(s_be),
    .mem_gnt_i(mem_gnt_i), .core_fetch_en_o(s_fetch), .load_busy_o(s_busy),
    .word_count_o(s_cnt), .err_overflow_o(s_ovf),
    .err_full_o(s_full), .err_frame_o(s_frame)
  );

  // Record every granted write (inputs are stable across the negedge).
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o && mem_gnt_i) wr_q.push_back({mem_addr_o, mem_wdata_o});
    if (rst_ni && s_req && mem_gnt_i) wr_s_q.push_back({s_addr, s_wdata});
  end

  // Hard time limit so the run always terminates.
  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_ss_i   = 1'b0;
      spi_mosi_i = w[31-i];
      tick();
    end
  endtask

  task automatic gap(input int n);
    spi_ss_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    sel_i      = 1'b0;
    en_i       = 1'b0;
    spi_ss_i   = 1'b1;
    spi_mosi_i = 1'b0;
    mem_gnt_i  = 1'b0;
    tick();
    tick();
    wr_q.delete();
    wr_s_q.delete();
    rst_ni = 1'b1;
  endtask

  // Reset, enable LOAD and advance into it.
  task automatic start_load(input logic gnt);
    do_reset();
    sel_i     = 1'b1;
    mem_gnt_i = gnt;
    tick();
    sel_i = 1'b0;
  endtask

  initial begin
    vec_t vecs[3];
    int   k;
    logic saw_req;

    vecs[0].word = 32'h0000_0013; vecs[0].exp_addr = 32'h0; vecs[0].exp_data = 32'h0000_0013;
    vecs[1].word = 32'hDEAD_BEEF; vecs[1].exp_addr = 32'h4; vecs[1].exp_data = 32'hDEAD_BEEF;
    vecs[2].word = 32'h1234_5678; vecs[2].exp_addr = 32'h8; vecs[2].exp_data = 32'h1234_5678;

    // ---- reset state ----
    rst_ni = 1'b0;
    tick();
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_fetch", {31'b0, core_fetch_en_o}, 32'h0);
    chk("rst_busy", {31'b0, load_busy_o}, 32'h0);
    chk("rst_cnt", {16'b0, word_count_o}, 32'h0);
    chk("rst_errs", {29'b0, err_overflow_o, err_full_o, err_frame_o}, 32'h0);
    chk("rst_be", {28'b0, mem_be_o}, 32'h0);

    // ---- 1: three words, grant tied high, then boot ----
    start_load(1'b1);
    chk("t1_busy", {31'b0, load_busy_o}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      send_bits(vecs[i].word, 32);
      spi_ss_i = 1'b1;
      chk($sformatf("t1_req%0d", i), {31'b0, mem_req_o}, 32'h1);
      chk($sformatf("t1_addr%0d", i), mem_addr_o, vecs[i].exp_addr);
      chk($sformatf("t1_data%0d", i), mem_wdata_o, vecs[i].exp_data);
      chk($sformatf("t1_be%0d", i), {28'b0, mem_be_o}, 32'hF);
      gap(3);
    end
    chk("t1_nwr", wr_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      chk($sformatf("t1_wr_addr%0d", i), wr_q[i][63:32], vecs[i].exp_addr);
      chk($sformatf("t1_wr_data%0d", i), wr_q[i][31:0], vecs[i].exp_data);
    end
    chk("t1_cnt", {16'b0, word_count_o}, 32'd3);
    en_i = 1'b1;
    chk("t1_fetch_pre", {31'b0, core_fetch_en_o}, 32'h0);
    tick();
    chk("t1_fetch", {31'b0, core_fetch_en_o}, 32'h1);
    chk("t1_errs", {29'b0, err_overflow_o, err_full_o, err_frame_o}, 32'h0);

    // ---- 2: grant withheld while two words stream back-to-back ----
    start_load(1'b0);
    send_bits(32'hCAFE_F00D, 32);
    chk("t2_req", {31'b0, mem_req_o}, 32'h1);
    send_bits(32'h0BAD_1DEA, 32);
    spi_ss_i = 1'b1;
    tick();
    chk("t2_req_hold", {31'b0, mem_req_o}, 32'h1);
    chk("t2_addr_hold", mem_addr_o, 32'h0);
    chk("t2_data_hold", mem_wdata_o, 32'hCAFE_F00D);
    chk("t2_ovf", {31'b0, err_overflow_o}, 32'h1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("t2_req_drop", {31'b0, mem_req_o}, 32'h0);
    chk("t2_cnt", {16'b0, word_count_o}, 32'd1);
    gap(3);
    chk("t2_nwr", wr_q.size(), 32'd1);

    // ---- 3: frame aborted after 17 bits, then a full word ----
    start_load(1'b1);
    send_bits(32'hFFFF_FFFF, 17);
    gap(1);
    chk("t3_frame", {31'b0, err_frame_o}, 32'h1);
    chk("t3_noreq", {31'b0, mem_req_o}, 32'h0);
    send_bits(32'hA5A5_A5A5, 32);
    gap(3);
    chk("t3_nwr", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) begin
      chk("t3_addr", wr_q[0][63:32], 32'h0);
      chk("t3_data", wr_q[0][31:0], 32'hA5A5_A5A5);
    end
    chk("t3_cnt", {16'b0, word_count_o}, 32'd1);

    // ---- 4: capacity of two words, three words sent ----
    start_load(1'b1);
    send_bits(32'h1111_1111, 32); gap(2);
    send_bits(32'h2222_2222, 32); gap(2);
    send_bits(32'h3333_3333, 32); gap(3);
    chk("t4_nwr_small", wr_s_q.size(), 32'd2);
    chk("t4_full_small", {31'b0, s_full}, 32'h1);
    chk("t4_cnt_small", {16'b0, s_cnt}, 32'd2);
    chk("t4_full_big", {31'b0, err_full_o}, 32'h0);
    chk("t4_cnt_big", {16'b0, word_count_o}, 32'd3);

    // ---- 5: en_i arrives with the last bit, grant delayed ----
    start_load(1'b0);
    send_bits(32'h8765_4321, 31);
    spi_ss_i   = 1'b0;
    spi_mosi_i = 1'b1;
    en_i       = 1'b1;
    tick();
    spi_ss_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_req%0d", i), {31'b0, mem_req_o}, 32'h1);
      chk($sformatf("t5_fetch%0d", i), {31'b0, core_fetch_en_o}, 32'h0);
      tick();
    end
    mem_gnt_i = 1'b1;
    chk("t5_fetch_gnt", {31'b0, core_fetch_en_o}, 32'h0);
    tick();
    mem_gnt_i = 1'b0;
    chk("t5_req_drop", {31'b0, mem_req_o}, 32'h0);
    k = 0;
    while (!core_fetch_en_o && k < 2) begin
      tick();
      k++;
    end
    chk("t5_fetch_after", {31'b0, core_fetch_en_o}, 32'h1);
    chk("t5_nwr", wr_q.size(), 32'd1);
    en_i = 1'b0;

    // ---- 6a: direct boot without loading ----
    do_reset();
    en_i = 1'b1;
    tick();
    chk("t6_fetch", {31'b0, core_fetch_en_o}, 32'h1);
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spi_ss_i   = i[0];
      spi_mosi_i = 1'b1;
      if (mem_req_o) saw_req = 1'b1;
      tick();
    end
    chk("t6_noreq", {31'b0, saw_req}, 32'h0);
    chk("t6_busy", {31'b0, load_busy_o}, 32'h0);

    // ---- 6b: asynchronous reset while a request is pending ----
    start_load(1'b0);
    send_bits(32'h5555_AAAA, 32);
    gap(1);
    chk("t6_req_before", {31'b0, mem_req_o}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_req_async", {31'b0, mem_req_o}, 32'h0);
    chk("t6_fetch_async", {31'b0, core_fetch_en_o}, 32'h0);
    chk("t6_busy_async", {31'b0, load_busy_o}, 32'h0);
    tick();
    rst_ni = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
